// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, rx state encoding and the 2-of-3 vote.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t ST_IDLE   = 3'd0;
   localparam rx_state_t ST_START  = 3'd1;
   localparam rx_state_t ST_DATA   = 3'd2;
   localparam rx_state_t ST_PARITY = 3'd3;
   localparam rx_state_t ST_STOP   = 3'd4;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer plus mid-bit sampler: captures counts M-1 and M, votes with the live M+1 sample.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          baud_tick,
   input  logic                          i_rx,
   input  logic [$clog2(OVERSAMPLE)-1:0] tick_cnt,
   output logic                          rx_sync,
   output logic                          bit_val
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_EARLY = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2);

   logic sync1_q, sync2_q;
   logic samp0_q, samp0_d;
   logic samp1_q, samp1_d;

   always_comb begin
      samp0_d = samp0_q;
      samp1_d = samp1_q;
      if (baud_tick && tick_cnt == CNT_EARLY) samp0_d = sync2_q;
      if (baud_tick && tick_cnt == CNT_MID)   samp1_d = sync2_q;
   end

   // Synchronizer and samples reset to 1 so a held-in-reset line looks idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         samp0_q <= 1'b1;
         samp1_q <= 1'b1;
      end else begin
         sync1_q <= i_rx;
         sync2_q <= sync1_q;
         samp0_q <= samp0_d;
         samp1_q <= samp1_d;
      end
   end

   assign rx_sync = sync2_q;
   assign bit_val = maj3(samp0_q, samp1_q, sync2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with ready/valid output, error flags and overrun pulse.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_tick,
   input  logic                 i_rx_data,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_break,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_LATE = CW'(OVERSAMPLE / 2 + 1);

   rx_state_t              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   par_bit_q, par_bit_d;
   logic                   ferr_q, ferr_d;
   logic                   done_q, done_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   perr_q, perr_d;
   logic                   frerr_q, frerr_d;
   logic                   brk_q, brk_d;
   logic                   ovr_q, ovr_d;
   logic                   rx_sync, bit_val, sample_now, frame_perr;

   uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
      .clk       (clk),
      .reset     (reset),
      .baud_tick (baud_tick),
      .i_rx      (i_rx_data),
      .tick_cnt  (cnt_q),
      .rx_sync   (rx_sync),
      .bit_val   (bit_val)
   );

   assign sample_now = baud_tick && cnt_q == CNT_LATE;
   assign frame_perr = (PARITY == PAR_ODD)  ? ~par_q :
                       (PARITY == PAR_EVEN) ?  par_q : 1'b0;

   // NOTE: every variable gets a default first so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      par_bit_d  = par_bit_q;
      ferr_d     = ferr_q;
      done_d     = 1'b0;
      if (baud_tick) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (!rx_sync) begin
                  state_d    = ST_START;
                  bit_cnt_d  = '0;
                  stop_cnt_d = 1'b0;
                  par_d      = 1'b0;
                  par_bit_d  = 1'b0;
                  ferr_d     = 1'b0;
               end
            end
            ST_START: begin
               if (sample_now && bit_val) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (sample_now) begin
                  shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
                  par_d     = par_q ^ bit_val;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
               if (cnt_q == CNT_LAST && bit_cnt_q == BW'(DATA_BITS))
                  state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: begin
               if (sample_now) begin
                  par_d     = par_q ^ bit_val;
                  par_bit_d = bit_val;
               end
               if (cnt_q == CNT_LAST) state_d = ST_STOP;
            end
            ST_STOP: begin
               if (sample_now) begin
                  if (!bit_val) ferr_d = 1'b1;
                  if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                     done_d  = 1'b1;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  stop_cnt_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output stage: a completion is loaded if the slot is empty or being drained this clk.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      frerr_d = frerr_q;
      brk_d   = brk_q;
      ovr_d   = 1'b0;
      if (done_q) begin
         if (!valid_q || i_rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = frame_perr;
            frerr_d = ferr_q;
            brk_d   = (shift_q == '0) && !par_bit_q && ferr_q;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && i_rx_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         par_bit_q  <= 1'b0;
         ferr_q     <= 1'b0;
         done_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         frerr_q    <= 1'b0;
         brk_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         par_bit_q  <= par_bit_d;
         ferr_q     <= ferr_d;
         done_q     <= done_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         frerr_q    <= frerr_d;
         brk_q      <= brk_d;
         ovr_q      <= ovr_d;
      end
   end

   assign o_rx_data    = data_q;
   assign o_rx_valid   = valid_q;
   assign o_parity_err = perr_q;
   assign o_frame_err  = frerr_q;
   assign o_break      = brk_q;
   assign o_overrun    = ovr_q;
   assign o_busy       = state_q != ST_IDLE;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 8N2) driven bit by bit and scored against a frame model.
module tb_uart_rx_cfg;
   import uart_pkg::*;

   localparam int OS = 16;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } frame_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic baud_tick;
   logic [1:0] tick_div = 2'd0;
   logic rx_a = 1'b1, rx_e = 1'b1, rx_n = 1'b1;
   logic rdy_a = 1'b1, rdy_e = 1'b1, rdy_n = 1'b1;

   logic [7:0] a_data, e_data, n_data;
   logic a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy;
   logic e_valid, e_perr, e_ferr, e_brk, e_ovr, e_busy;
   logic n_valid, n_perr, n_ferr, n_brk, n_ovr, n_busy;

   frame_t q_a[$], q_e[$], q_n[$];
   frame_t exp_q[$];
   int a_vcyc = 0, a_ovr_cyc = 0;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   // Tick every third clock so tick gating matters.
   always @(posedge clk) tick_div <= (tick_div == 2'd2) ? 2'd0 : tick_div + 2'd1;
   assign baud_tick = (tick_div == 2'd2);

   uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(reset), .baud_tick(baud_tick), .i_rx_data(rx_a),
      .o_rx_data(a_data), .o_rx_valid(a_valid), .i_rx_ready(rdy_a),
      .o_parity_err(a_perr), .o_frame_err(a_ferr), .o_break(a_brk),
      .o_overrun(a_ovr), .o_busy(a_busy));

   uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_e (
      .clk(clk), .reset(reset), .baud_tick(baud_tick), .i_rx_data(rx_e),
      .o_rx_data(e_data), .o_rx_valid(e_valid), .i_rx_ready(rdy_e),
      .o_parity_err(e_perr), .o_frame_err(e_ferr), .o_break(e_brk),
      .o_overrun(e_ovr), .o_busy(e_busy));

   uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_n (
      .clk(clk), .reset(reset), .baud_tick(baud_tick), .i_rx_data(rx_n),
      .o_rx_data(n_data), .o_rx_valid(n_valid), .i_rx_ready(rdy_n),
      .o_parity_err(n_perr), .o_frame_err(n_ferr), .o_break(n_brk),
      .o_overrun(n_ovr), .o_busy(n_busy));

   // Record every accepted word and count valid/overrun cycles.
   always @(negedge clk) begin
      #1;
      if (a_valid && rdy_a) q_a.push_back({a_data, a_perr, a_ferr, a_brk});
      if (e_valid && rdy_e) q_e.push_back({e_data, e_perr, e_ferr, e_brk});
      if (n_valid && rdy_n) q_n.push_back({n_data, n_perr, n_ferr, n_brk});
      if (a_valid) a_vcyc++;
      if (a_ovr) a_ovr_cyc++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected word from the frame's line content.
   function automatic frame_t model(input logic [7:0] d, input int mode, input logic pbit,
                                    input logic [1:0] stops, input int nstop);
      frame_t f;
      int ones;
      ones = $countones(d) + ((mode != PAR_NONE) ? int'(pbit) : 0);
      f.data = d;
      f.ferr = 1'b0;
      for (int s = 0; s < nstop; s++) if (!stops[s]) f.ferr = 1'b1;
      f.perr = (mode == PAR_ODD) ? (ones % 2 == 0) : (mode == PAR_EVEN) ? (ones % 2 == 1) : 1'b0;
      f.brk  = (d == 8'h00) && (mode == PAR_NONE || !pbit) && f.ferr;
      return f;
   endfunction

   task automatic wait_tick();
      do @(negedge clk); while (!baud_tick);
   endtask

   task automatic drive(input int which, input logic v);
      case (which)
         0: rx_a = v;
         1: rx_e = v;
         default: rx_n = v;
      endcase
   endtask

   task automatic send_bit(input int which, input logic v, input int glitch_at);
      drive(which, v);
      for (int t = 0; t < OS; t++) begin
         if (t == glitch_at) drive(which, ~v);
         else if (t == glitch_at + 1) drive(which, v);
         wait_tick();
      end
   endtask

   task automatic idle(input int which, input int nbits);
      for (int i = 0; i < nbits; i++) send_bit(which, 1'b1, -1);
   endtask

   task automatic send_frame(input int which, input logic [7:0] d, input int mode, input logic pbit,
                             input logic [1:0] stops, input int nstop, input int glitch_bit);
      send_bit(which, 1'b0, -1);
      for (int i = 0; i < 8; i++) send_bit(which, d[i], (i == glitch_bit) ? 9 : -1);
      if (mode != PAR_NONE) send_bit(which, pbit, -1);
      for (int s = 0; s < nstop; s++) send_bit(which, stops[s], -1);
   endtask

   function automatic int qsize(input int which);
      case (which)
         0: return q_a.size();
         1: return q_e.size();
         default: return q_n.size();
      endcase
   endfunction

   function automatic frame_t pop(input int which);
      frame_t f;
      f = 'x;
      case (which)
         0: if (q_a.size() > 0) f = q_a.pop_front();
         1: if (q_e.size() > 0) f = q_e.pop_front();
         default: if (q_n.size() > 0) f = q_n.pop_front();
      endcase
      return f;
   endfunction

   task automatic wait_q(input int which, input int n, input string tag);
      int k = 0;
      while (qsize(which) < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check(tag, qsize(which), n);
   endtask

   initial begin
      frame_t f;
      logic [7:0] d;
      logic pb;
      logic [1:0] st;

      repeat (5) @(negedge clk);
      check("rst_data", a_data, 0);
      check("rst_valid", a_valid, 0);
      check("rst_flags", {a_perr, a_ferr, a_brk, a_ovr}, 0);
      check("rst_busy", a_busy, 0);
      reset = 1'b0;
      idle(0, 2);

      // 8N1 single frame, valid for exactly one clk
      a_vcyc = 0;
      send_frame(0, 8'hA5, PAR_NONE, 1'b0, 2'b11, 1, -1);
      idle(0, 1);
      wait_q(0, 1, "a5_count");
      check("a5_frame", pop(0), model(8'hA5, PAR_NONE, 1'b0, 2'b11, 1));
      check("a5_valid_cycles", a_vcyc, 1);

      // 8N1 random back-to-back frames
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         exp_q.push_back(model(d, PAR_NONE, 1'b0, 2'b11, 1));
         send_frame(0, d, PAR_NONE, 1'b0, 2'b11, 1, -1);
      end
      idle(0, 2);
      wait_q(0, 6, "rnd_n1_count");
      for (int i = 0; i < 6; i++) check("rnd_n1_frame", pop(0), exp_q[i]);

      // one glitched sample mid-bit is outvoted
      send_frame(0, 8'h3C, PAR_NONE, 1'b0, 2'b11, 1, 3);
      idle(0, 1);
      wait_q(0, 1, "glitch_count");
      check("glitch_frame", pop(0), model(8'h3C, PAR_NONE, 1'b0, 2'b11, 1));

      // false start: line low for 5 ticks
      rx_a = 1'b0;
      repeat (5) wait_tick();
      check("fs_busy_hi", a_busy, 1);
      idle(0, 2);
      check("fs_busy_lo", a_busy, 0);
      check("fs_no_valid", qsize(0), 0);

      // 8E1 directed parity
      send_frame(1, 8'h03, PAR_EVEN, 1'b1, 2'b11, 1, -1);
      send_frame(1, 8'h03, PAR_EVEN, 1'b0, 2'b11, 1, -1);
      idle(1, 1);
      wait_q(1, 2, "e1_count");
      check("e1_perr_set", pop(1), model(8'h03, PAR_EVEN, 1'b1, 2'b11, 1));
      check("e1_perr_clr", pop(1), model(8'h03, PAR_EVEN, 1'b0, 2'b11, 1));

      // 8E1 random data, parity bit and stop bit
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         d  = 8'($urandom_range(0, 255));
         pb = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'b10;
         exp_q.push_back(model(d, PAR_EVEN, pb, st, 1));
         send_frame(1, d, PAR_EVEN, pb, st, 1, -1);
         if (!st[0]) idle(1, 2);
      end
      idle(1, 2);
      wait_q(1, 6, "rnd_e1_count");
      for (int i = 0; i < 6; i++) check("rnd_e1_frame", pop(1), exp_q[i]);

      // 8N2 break: line low for 12 bit times
      for (int i = 0; i < 12; i++) send_bit(2, 1'b0, -1);
      idle(2, 12);
      check("brk_seen", qsize(2) >= 1, 1);
      check("brk_frame", pop(2), model(8'h00, PAR_NONE, 1'b0, 2'b00, 2));
      q_n.delete();
      send_frame(2, 8'h7E, PAR_NONE, 1'b0, 2'b01, 2, -1);
      idle(2, 2);
      wait_q(2, 1, "stop2_count");
      check("stop2_frame", pop(2), model(8'h7E, PAR_NONE, 1'b0, 2'b01, 2));

      // overrun: second frame dropped while first is held
      rdy_a = 1'b0;
      a_ovr_cyc = 0;
      send_frame(0, 8'h11, PAR_NONE, 1'b0, 2'b11, 1, -1);
      send_frame(0, 8'h22, PAR_NONE, 1'b0, 2'b11, 1, -1);
      idle(0, 2);
      check("ovr_valid_held", a_valid, 1);
      check("ovr_data_held", a_data, 8'h11);
      check("ovr_pulses", a_ovr_cyc, 1);
      rdy_a = 1'b1;
      repeat (2) @(negedge clk);
      check("ovr_accept", pop(0), model(8'h11, PAR_NONE, 1'b0, 2'b11, 1));
      check("ovr_valid_drop", a_valid, 0);

      // reset during bit 4 while a word is held
      rdy_a = 1'b0;
      send_frame(0, 8'h33, PAR_NONE, 1'b0, 2'b11, 1, -1);
      idle(0, 1);
      check("pre_rst_valid", a_valid, 1);
      d = 8'h5A;
      send_bit(0, 1'b0, -1);
      for (int i = 0; i < 4; i++) send_bit(0, d[i], -1);
      rx_a = d[4];
      repeat (8) wait_tick();
      reset = 1'b1;
      rx_a = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_valid", a_valid, 0);
      check("mid_rst_data", a_data, 0);
      check("mid_rst_busy", a_busy, 0);
      check("mid_rst_flags", {a_perr, a_ferr, a_brk, a_ovr}, 0);
      reset = 1'b0;
      rdy_a = 1'b1;
      idle(0, 2);
      check("post_rst_empty", qsize(0), 0);
      send_frame(0, 8'h5A, PAR_NONE, 1'b0, 2'b11, 1, -1);
      idle(0, 1);
      wait_q(0, 1, "post_rst_count");
      check("post_rst_frame", pop(0), model(8'h5A, PAR_NONE, 1'b0, 2'b11, 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, baud_tick periods per bit; legal values 8 or 16.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits expected; legal values 1 or 2.
REQ-005 clk  input  1  system clock; reset  input  1  asynchronous, active-high.
REQ-006 baud_tick  input  1  one-clk strobe at OVERSAMPLE x baud rate.
REQ-007 i_rx_data  input  1  asynchronous serial line; idles high.
REQ-008 o_rx_data  output  DATA_BITS  received payload, LSB first on the line.
REQ-009 o_rx_valid  output  1  payload and status flags are valid.
REQ-010 i_rx_ready  input  1  consumer accepts the word.
REQ-011 o_parity_err, o_frame_err, o_break  output  1 each  status flags qualified by o_rx_valid.
REQ-012 o_overrun  output  1  one-clk pulse when a completed frame is dropped.
REQ-013 o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 i_rx_data SHALL pass through a 2-flop synchronizer before any use.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-016 All counters, sampling and state transitions SHALL advance only on clk edges with baud_tick=1.
REQ-017 IDLE→START when the synchronized line is 0 on a tick; the tick counter SHALL clear to 0.
REQ-018 Within each bit, the tick counter SHALL run 0..OVERSAMPLE-1.
REQ-019 Each bit value SHALL be the 2-of-3 majority of the samples at counts M-1, M and M+1, where M=OVERSAMPLE/2.
REQ-020 START: a majority of 1 SHALL be a false start and return to IDLE with no outputs changed; otherwise go to DATA at count OVERSAMPLE-1.
REQ-021 DATA: bits SHALL shift in LSB first; after DATA_BITS bits go to PARITY (or to STOP when PARITY=0).
REQ-022 PARITY: o_parity_err SHALL be 1 when the XOR of the data bits and the parity bit is wrong for the selected mode (odd: XOR must be 1; even: XOR must be 0); always 0 when PARITY=0.
REQ-023 STOP: o_frame_err SHALL be 1 if any stop bit samples 0.
REQ-024 At the M+1 sample of the last stop bit, the FSM SHALL go to IDLE; this allows back-to-back frames with no idle gap.
REQ-025 o_break SHALL be 1 when the payload is all zero, the parity bit (if present) is 0 and o_frame_err=1.
REQ-026 Output load: o_rx_valid SHALL rise 1 clk after the final stop sample, with data and flags registered together.
REQ-027 o_rx_valid SHALL stay high and the data and flags SHALL stay stable until a clk with o_rx_valid and i_rx_ready both high; valid SHALL then drop.
REQ-028 A frame that completes while o_rx_valid=1 and i_rx_ready=0 SHALL be discarded, with o_overrun pulsed for 1 clk.
REQ-029 When a handshake and a frame completion occur in the same clk, the new frame SHALL be loaded and o_overrun SHALL stay 0.
REQ-030 Frames with errors SHALL still be delivered, with their flags set.

Reset
REQ-031 Reset SHALL force IDLE, clear all counters and the shift register, set synchronizer flops to 1, and drive every output to 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; reception SHALL restart only at the next falling edge after reset is released.

Structure
REQ-033 Shared package uart_pkg SHALL hold the parity-mode constants (NONE/ODD/EVEN) and the rx state encoding.
REQ-034 One sub-module, uart_rx_sampler, SHALL hold the synchronizer and 3-sample majority voter.
REQ-035 The parity check SHALL be a running XOR register, not a post-frame reduction.

Verification
REQ-036 8N1, OVERSAMPLE=16: send 0xA5, ready=1 → o_rx_data=0xA5 with valid for 1 clk and all flags 0.
REQ-037 8E1: send 0x03 with parity bit 1 → data 0x03, o_parity_err=1; repeat with parity bit 0 → o_parity_err=0.
REQ-038 Line low for 5 ticks then high → no valid, o_busy returns to 0; a single glitched sample mid-bit does not change the decoded byte.
REQ-039 ready=0, two back-to-back frames 0x11 and 0x22 → o_rx_data stays 0x11, o_overrun pulses once; raising ready accepts 0x11.
REQ-040 8N2, line held low for 12 bit times → data 0x00 with o_frame_err=1 and o_break=1; a second stop bit of 0 on 0x7E → o_frame_err=1, o_break=0.
REQ-041 Reset asserted during bit 4 of a frame → outputs 0 and state IDLE; the next full frame 0x5A is received correctly.
